// File: rtl/fetch_queue_if.sv
// fetch_queue_if: decode, EX redirect and instruction-memory signals of the prefetch queue
interface fetch_queue_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
);
    logic                         J;
    logic [ADDR_W-1:0]            TA;
    logic                         LE;
    logic [ADDR_W-1:0]            imem_addr;
    logic [INSTR_W-1:0]           imem_data;
    logic [ADDR_W-1:0]            B_PC;
    logic [INSTR_W-1:0]           instruction;
    logic                         valid;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;
    modport master (
        input  J, TA, LE, imem_data,
        output imem_addr, B_PC, instruction, valid, count, full, empty
    );
    modport slave (
        output J, TA, LE, imem_data,
        input  imem_addr, B_PC, instruction, valid, count, full, empty
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FIFO owning the fetch PC, flushed and redirected by taken branches
module fetch_queue #(
    parameter int                 ADDR_W    = 8,
    parameter int                 INSTR_W   = 32,
    parameter int                 DEPTH     = 4,
    parameter int                 PC_STEP   = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input logic             CLK,
    input logic             RST,
    fetch_queue_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic               valid;
    logic               full;
    logic               pop;
    logic               push;

    // queue status and the push/pop decisions for this cycle
    always_comb begin
        valid = cnt != '0;
        full  = cnt == CW'(DEPTH);
        pop   = bus.LE & valid & ~bus.J;
        push  = ~bus.J & (~full | pop);
    end

    // pointers, occupancy and fetch PC; reset beats flush, flush beats push/pop
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.J) begin
            pc     <= bus.TA;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc + ADDR_W'(PC_STEP);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // entry storage; stale contents are masked by valid so no reset is needed
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            addr_mem[wr_ptr] <= pc;
            data_mem[wr_ptr] <= bus.imem_data;
        end
    end

    // show-ahead head entry, all outputs purely from registers
    always_comb begin
        bus.imem_addr   = pc;
        bus.valid       = valid;
        bus.full        = full;
        bus.empty       = ~valid;
        bus.count       = cnt;
        bus.B_PC        = valid ? addr_mem[rd_ptr] : '0;
        bus.instruction = valid ? data_mem[rd_ptr] : NOP_INSTR;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based model
module tb_fetch_queue;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic CLK = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_STEP(4), .NOP_INSTR('0)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [INSTR_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        return (32'h0101_0101 * {24'h0, a}) ^ 32'hDEAD_0000;
    endfunction

    assign bus.imem_data = mem_f(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: a plain queue of {addr, data} plus a fetch address
    logic [ADDR_W+INSTR_W-1:0] q[$];
    logic [ADDR_W-1:0]         mpc;
    bit                        mready = 0;

    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
            mpc = '0;
            mready = 1;
        end else if (mready) begin
            if (bus.J) begin
                q.delete();
                mpc = bus.TA;
            end else begin
                bit was_full;
                bit do_pop;
                was_full = q.size() == DEPTH;
                do_pop = bus.LE && q.size() > 0;
                if (do_pop) void'(q.pop_front());
                if (!was_full || do_pop) begin
                    q.push_back({mpc, mem_f(mpc)});
                    mpc = mpc + 8'd4;
                end
            end
        end
    end

    // compare every cycle once the model has seen a reset
    always @(posedge CLK) begin
        #1;
        if (mready) begin
            logic [ADDR_W-1:0]  e_pc;
            logic [INSTR_W-1:0] e_ins;
            e_pc  = q.size() > 0 ? q[0][ADDR_W+INSTR_W-1:INSTR_W] : '0;
            e_ins = q.size() > 0 ? q[0][INSTR_W-1:0] : '0;
            chk("m_imem_addr", 32'(bus.imem_addr), 32'(mpc));
            chk("m_valid", 32'(bus.valid), 32'(q.size() > 0));
            chk("m_count", 32'(bus.count), 32'(q.size()));
            chk("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
            chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
            chk("m_b_pc", 32'(bus.B_PC), 32'(e_pc));
            chk("m_instr", bus.instruction, e_ins);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.J = 1'b0;
        bus.TA = '0;
        bus.LE = 1'b0;
        cyc(2);
        chk("rst_addr", 32'(bus.imem_addr), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_instr", bus.instruction, 32'h0);
        // streaming with LE=1
        RST = 1'b0;
        bus.LE = 1'b1;
        cyc();
        chk("t1_valid", 32'(bus.valid), 32'h1);
        chk("t1_bpc0", 32'(bus.B_PC), 32'h0);
        chk("t1_ins0", bus.instruction, 32'hDEAD_0000);
        cyc();
        chk("t1_bpc4", 32'(bus.B_PC), 32'h4);
        chk("t1_ins4", bus.instruction, 32'hDEAD_0000 ^ 32'h0404_0404);
        chk("t1_cnt", 32'(bus.count), 32'h1);
        // fill up with LE=0
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        bus.LE = 1'b0;
        cyc(4);
        chk("t2_full", 32'(bus.full), 32'h1);
        chk("t2_addr", 32'(bus.imem_addr), 32'h10);
        cyc();
        chk("t2_hold", 32'(bus.imem_addr), 32'h10);
        chk("t2_head", 32'(bus.B_PC), 32'h0);
        bus.LE = 1'b1;
        cyc();
        chk("t4_bpc", 32'(bus.B_PC), 32'h4);
        chk("t4_cnt", 32'(bus.count), 32'h4);
        chk("t4_addr", 32'(bus.imem_addr), 32'h14);
        cyc();
        chk("t4_bpc2", 32'(bus.B_PC), 32'h8);
        // flush with three entries queued
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        bus.LE = 1'b0;
        cyc(3);
        chk("t3_cnt3", 32'(bus.count), 32'h3);
        bus.J = 1'b1;
        bus.TA = 8'h40;
        cyc();
        chk("t3_valid", 32'(bus.valid), 32'h0);
        chk("t3_cnt", 32'(bus.count), 32'h0);
        chk("t3_instr", bus.instruction, 32'h0);
        chk("t3_addr", 32'(bus.imem_addr), 32'h40);
        bus.J = 1'b0;
        cyc();
        chk("t3_bpc", 32'(bus.B_PC), 32'h40);
        // wrap past the top of the address space
        bus.J = 1'b1;
        bus.TA = 8'hF8;
        cyc();
        bus.J = 1'b0;
        bus.LE = 1'b1;
        cyc();
        chk("t5_f8", 32'(bus.B_PC), 32'hF8);
        cyc();
        chk("t5_fc", 32'(bus.B_PC), 32'hFC);
        cyc();
        chk("t5_00", 32'(bus.B_PC), 32'h00);
        cyc();
        chk("t5_04", 32'(bus.B_PC), 32'h04);
        // reset wins over a simultaneous jump with the queue full
        bus.LE = 1'b0;
        cyc(5);
        chk("t6_full", 32'(bus.full), 32'h1);
        RST = 1'b1;
        bus.J = 1'b1;
        bus.TA = 8'h80;
        cyc();
        chk("t6_cnt", 32'(bus.count), 32'h0);
        chk("t6_bpc", 32'(bus.B_PC), 32'h0);
        chk("t6_addr", 32'(bus.imem_addr), 32'h0);
        RST = 1'b0;
        bus.J = 1'b0;
        cyc();
        chk("t6_next", 32'(bus.B_PC), 32'h0);
        // random traffic, with phases biased towards stalls or streaming
        for (int i = 0; i < 3000; i++) begin
            int le_pct;
            le_pct = (i / 200) % 3 == 0 ? 20 : ((i / 200) % 3 == 1 ? 90 : 50);
            RST = $urandom_range(0, 99) == 0;
            bus.J = $urandom_range(0, 99) < 8;
            bus.TA = ADDR_W'($urandom);
            bus.LE = $urandom_range(0, 99) < le_pct;
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
